// File: rtl/mini16_s2m_arbiter.sv
// mini16_s2m_arbiter
// Round-robin scheduler that drains the slave-to-master FIFOs of N_CORES
// processing elements into a single master write port. Each PE receives a
// fixed slot of BURST request cycles followed by FIFO_LATENCY drain cycles.
// Every item that is returned is forwarded as a one-cycle write.
//
// Optional feature: define MINI16_S2M_ARB_COUNT_EN to add the 32-bit m_count
// port. This port counts forwarded items.
//
// Timing note: state_r/cur_r/ph_r describe the slot cycle that the *next*
// clock cycle will execute. fifo_req_r is registered from them, so the reset
// values (REQ, core 0, phase 0) coincide with fifo_req_r = 0. The first request
// for core 0 appears at the first edge that samples reset low. slot_core_r
// follows the core whose slot the port is executing right now. Captures are
// steered by slot_core_r. At the slot edge, the last drain cycle's capture
// therefore still uses the old core.

module mini16_s2m_arbiter #(
  parameter int WIDTH_D      = 16,
  parameter int DEPTH_V_F    = 16,
  parameter int N_CORES      = 4,
  parameter int CORE_BITS    = 2,
  parameter int BURST        = 4,
  parameter int FIFO_LATENCY = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  output logic [N_CORES-1:0]                      fifo_req_r,
  input  logic [N_CORES-1:0]                      fifo_valid,
  input  logic [N_CORES*(WIDTH_D+DEPTH_V_F)-1:0]  fifo_r_data,
  output logic                                    m_we,
  output logic [DEPTH_V_F-1:0]                    m_addr,
  output logic [WIDTH_D-1:0]                      m_data,
  output logic [CORE_BITS-1:0]                    m_core
`ifdef MINI16_S2M_ARB_COUNT_EN
  ,
  output logic [31:0]                             m_count
`endif
);

  localparam int ITEM_W   = WIDTH_D + DEPTH_V_F;
  localparam int SLOT_LEN = BURST + FIFO_LATENCY;
  localparam int PH_BITS  = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

  localparam logic [PH_BITS-1:0]   PH_REQ_LAST  = PH_BITS'(BURST - 1);
  localparam logic [PH_BITS-1:0]   PH_SLOT_LAST = PH_BITS'(SLOT_LEN - 1);
  localparam logic [CORE_BITS-1:0] CORE_LAST    = CORE_BITS'(N_CORES - 1);

  typedef enum logic [0:0] {
    ST_REQ   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // One-hot decode of a core index. Indices at or above N_CORES decode to all zeros.
  function automatic logic [N_CORES-1:0] core_onehot(input logic [CORE_BITS-1:0] idx);
    logic [N_CORES-1:0] vec;
    vec = {N_CORES{1'b0}};
    for (int i = 0; i < N_CORES; i++) begin
      vec[i] = (idx == CORE_BITS'(i));
    end
    return vec;
  endfunction

  // Select one PE's {addr, data} item from the packed read-data bus.
  function automatic logic [ITEM_W-1:0] item_of(input logic [N_CORES*ITEM_W-1:0] bus,
                                                input logic [CORE_BITS-1:0]       idx);
    logic [ITEM_W-1:0] item;
    item = {ITEM_W{1'b0}};
    for (int i = 0; i < N_CORES; i++) begin
      item = item | (bus[i*ITEM_W +: ITEM_W] & {ITEM_W{idx == CORE_BITS'(i)}});
    end
    return item;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CORE_BITS-1:0] cur_r;
  logic [CORE_BITS-1:0] cur_nxt_s;
  logic [PH_BITS-1:0]   ph_r;
  logic [PH_BITS-1:0]   ph_nxt_s;
  logic [N_CORES-1:0]   req_nxt_s;
  logic [CORE_BITS-1:0] slot_core_r;
  logic                 sel_valid_s;
  logic [ITEM_W-1:0]    sel_item_s;

  // Slot sequencing: REQ for BURST phases, DRAIN for FIFO_LATENCY phases, then the next core.
  always_comb begin
    state_nxt_s = state_r;
    cur_nxt_s   = cur_r;
    ph_nxt_s    = ph_r + PH_BITS'(1);
    req_nxt_s   = {N_CORES{1'b0}};
    case (state_r)
      ST_REQ: begin
        req_nxt_s = core_onehot(cur_r);
        if (ph_r == PH_REQ_LAST) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (ph_r == PH_SLOT_LAST) begin
          state_nxt_s = ST_REQ;
          ph_nxt_s    = {PH_BITS{1'b0}};
          if (cur_r == CORE_LAST) begin
            cur_nxt_s = {CORE_BITS{1'b0}};
          end else begin
            cur_nxt_s = cur_r + CORE_BITS'(1);
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_REQ;
        cur_nxt_s   = {CORE_BITS{1'b0}};
        ph_nxt_s    = {PH_BITS{1'b0}};
      end
    endcase
  end

  // Return-path steering: only the executing slot's PE is listened to.
  always_comb begin
    sel_valid_s = |(fifo_valid & core_onehot(slot_core_r));
    sel_item_s  = item_of(fifo_r_data, slot_core_r);
  end

  // Slot state, registered request vector and the executing-slot core tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_REQ;
      cur_r       <= {CORE_BITS{1'b0}};
      ph_r        <= {PH_BITS{1'b0}};
      fifo_req_r  <= {N_CORES{1'b0}};
      slot_core_r <= {CORE_BITS{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cur_r       <= cur_nxt_s;
      ph_r        <= ph_nxt_s;
      fifo_req_r  <= req_nxt_s;
      slot_core_r <= cur_r;
    end
  end

  // Master write port: one registered write per returned item; fields hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_we   <= 1'b0;
      m_addr <= {DEPTH_V_F{1'b0}};
      m_data <= {WIDTH_D{1'b0}};
      m_core <= {CORE_BITS{1'b0}};
    end else begin
      m_we <= sel_valid_s;
      if (sel_valid_s) begin
        m_addr <= sel_item_s[ITEM_W-1:WIDTH_D];
        m_data <= sel_item_s[WIDTH_D-1:0];
        m_core <= slot_core_r;
      end
    end
  end

`ifdef MINI16_S2M_ARB_COUNT_EN
  // Forwarded-item counter; increments alongside each registered write and wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_count <= 32'd0;
    end else if (sel_valid_s) begin
      m_count <= m_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mini16_s2m_arbiter.sv
// Directed self-checking bench for mini16_s2m_arbiter (default parameters).
// A behavioural PE FIFO model answers each observed request FIFO_LATENCY
// cycles later. Forwarded writes are logged with their cycle number, counted
// from the first cycle after the reset edge (cycle 0), and compared against
// hand-computed tables.
module tb_mini16_s2m_arbiter;

  localparam int WIDTH_D      = 16;
  localparam int DEPTH_V_F    = 16;
  localparam int N_CORES      = 4;
  localparam int CORE_BITS    = 2;
  localparam int BURST        = 4;
  localparam int FIFO_LATENCY = 2;
  localparam int ITEM_W       = WIDTH_D + DEPTH_V_F;
  localparam int QDEPTH       = 16;

  logic                        clk;
  logic                        reset;
  logic [N_CORES-1:0]          fifo_req_r;
  logic [N_CORES-1:0]          fifo_valid;
  logic [N_CORES*ITEM_W-1:0]   fifo_r_data;
  logic                        m_we;
  logic [DEPTH_V_F-1:0]        m_addr;
  logic [WIDTH_D-1:0]          m_data;
  logic [CORE_BITS-1:0]        m_core;
`ifdef MINI16_S2M_ARB_COUNT_EN
  logic [31:0]                 m_count;
`endif

  int total;
  int bad;
  int cyc;

  logic [ITEM_W-1:0]    fmem [N_CORES][QDEPTH];
  int                   rd_ptr [N_CORES];
  int                   wr_ptr [N_CORES];
  logic                 pipe_v    [FIFO_LATENCY];
  logic [CORE_BITS-1:0] pipe_core [FIFO_LATENCY];
  logic [ITEM_W-1:0]    pipe_item [FIFO_LATENCY];

  int                   ev_cyc  [$];
  logic [DEPTH_V_F-1:0] ev_addr [$];
  logic [WIDTH_D-1:0]   ev_data [$];
  logic [CORE_BITS-1:0] ev_core [$];

  mini16_s2m_arbiter #(
    .WIDTH_D      (WIDTH_D),
    .DEPTH_V_F    (DEPTH_V_F),
    .N_CORES      (N_CORES),
    .CORE_BITS    (CORE_BITS),
    .BURST        (BURST),
    .FIFO_LATENCY (FIFO_LATENCY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_req_r  (fifo_req_r),
    .fifo_valid  (fifo_valid),
    .fifo_r_data (fifo_r_data),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_core      (m_core)
`ifdef MINI16_S2M_ARB_COUNT_EN
    ,
    .m_count     (m_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_fifos();
    for (int i = 0; i < N_CORES; i++) begin
      rd_ptr[i] = 0;
      wr_ptr[i] = 0;
    end
  endtask

  task automatic push_item(input int core, input logic [15:0] addr, input logic [15:0] data);
    fmem[core][wr_ptr[core]] = {addr, data};
    wr_ptr[core] = wr_ptr[core] + 1;
  endtask

  // Called once per cycle at the negedge: log the write, check that at most one
  // request bit is high, drive this cycle's return, then accept new requests.
  task automatic model_cycle();
    logic [N_CORES-1:0] req;
    int idx;
    req = fifo_req_r;
    if (m_we === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_addr.push_back(m_addr);
      ev_data.push_back(m_data);
      ev_core.push_back(m_core);
    end
    total++;
    if ($countones(req) > 1) begin
      bad++;
      $display("FAIL req_onehot cyc=%0d got=%b want=at most one bit", cyc, req);
    end
    fifo_valid  = {N_CORES{1'b0}};
    fifo_r_data = {(N_CORES*ITEM_W){1'b0}};
    if (pipe_v[FIFO_LATENCY-1]) begin
      idx = int'(pipe_core[FIFO_LATENCY-1]);
      fifo_valid[idx] = 1'b1;
      fifo_r_data[idx*ITEM_W +: ITEM_W] = pipe_item[FIFO_LATENCY-1];
    end
    for (int k = FIFO_LATENCY - 1; k > 0; k--) begin
      pipe_v[k]    = pipe_v[k-1];
      pipe_core[k] = pipe_core[k-1];
      pipe_item[k] = pipe_item[k-1];
    end
    pipe_v[0] = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (req[i] && (rd_ptr[i] < wr_ptr[i])) begin
        pipe_v[0]    = 1'b1;
        pipe_core[0] = CORE_BITS'(i);
        pipe_item[0] = fmem[i][rd_ptr[i]];
        rd_ptr[i]    = rd_ptr[i] + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    model_cycle();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Reset is sampled high at exactly one edge; in-flight model returns are discarded.
  task automatic do_reset();
    reset       = 1'b1;
    fifo_valid  = {N_CORES{1'b0}};
    fifo_r_data = {(N_CORES*ITEM_W){1'b0}};
    for (int k = 0; k < FIFO_LATENCY; k++) pipe_v[k] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    ev_cyc.delete();
    ev_addr.delete();
    ev_data.delete();
    ev_core.delete();
    model_cycle();
  endtask

  task automatic check_events(input string name, input int n_exp, input int exp_c [],
                              input logic [15:0] exp_a [], input logic [15:0] exp_d [],
                              input logic [1:0] exp_k []);
    int n;
    total++;
    if (ev_cyc.size() != n_exp) begin
      bad++;
      $display("FAIL %s_count got=%0d want=%0d", name, ev_cyc.size(), n_exp);
    end
    n = (ev_cyc.size() < n_exp) ? ev_cyc.size() : n_exp;
    for (int k = 0; k < n; k++) begin
      total += 4;
      if (ev_cyc[k] != exp_c[k]) begin
        bad++;
        $display("FAIL %s_cycle[%0d] got=%0d want=%0d", name, k, ev_cyc[k], exp_c[k]);
      end
      if (ev_addr[k] !== exp_a[k]) begin
        bad++;
        $display("FAIL %s_addr[%0d] got=%h want=%h", name, k, ev_addr[k], exp_a[k]);
      end
      if (ev_data[k] !== exp_d[k]) begin
        bad++;
        $display("FAIL %s_data[%0d] got=%h want=%h", name, k, ev_data[k], exp_d[k]);
      end
      if (ev_core[k] !== exp_k[k]) begin
        bad++;
        $display("FAIL %s_core[%0d] got=%0d want=%0d", name, k, ev_core[k], exp_k[k]);
      end
    end
  endtask

  task automatic test_reset();
    clear_fifos();
    do_reset();
    total += 5;
    if (fifo_req_r !== 4'b0000) begin bad++; $display("FAIL rst_req got=%b want=0000", fifo_req_r); end
    if (m_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", m_we); end
    if (m_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h want=0000", m_addr); end
    if (m_data !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h want=0000", m_data); end
    if (m_core !== 2'd0) begin bad++; $display("FAIL rst_core got=%0d want=0", m_core); end
`ifdef MINI16_S2M_ARB_COUNT_EN
    total++;
    if (m_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%h want=0", m_count); end
`endif
  endtask

  // Empty FIFOs: slot k occupies cycles 1+6k..6+6k, requesting in its first 4 cycles.
  task automatic test_idle();
    logic [3:0] exp;
    int pos;
    int slot;
    for (int c = 1; c <= 25; c++) begin
      step();
      pos  = (c - 1) % 6;
      slot = (c - 1) / 6;
      exp  = (pos < 4) ? (4'b0001 << (slot % 4)) : 4'b0000;
      total += 2;
      if (fifo_req_r !== exp) begin
        bad++;
        $display("FAIL idle_req cyc=%0d got=%b want=%b", c, fifo_req_r, exp);
      end
      if (m_we !== 1'b0) begin
        bad++;
        $display("FAIL idle_we cyc=%0d got=%b want=0", c, m_we);
      end
    end
  endtask

  // PE2 slot = cycles 13..18: pops at 13,14,15, returns at 15,16,17, writes at 16,17,18.
  task automatic test_pe2_burst();
    int          ec [] = '{16, 17, 18};
    logic [15:0] ea [] = '{16'h0010, 16'h0011, 16'h0012};
    logic [15:0] ed [] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    logic [1:0]  ek [] = '{2'd2, 2'd2, 2'd2};
    clear_fifos();
    do_reset();
    push_item(2, 16'h0010, 16'hAAAA);
    push_item(2, 16'h0011, 16'hBBBB);
    push_item(2, 16'h0012, 16'hCCCC);
    run_to(30);
    check_events("pe2", 3, ec, ea, ed, ek);
    total += 3;
    if (m_we !== 1'b0) begin bad++; $display("FAIL pe2_idle_we got=%b want=0", m_we); end
    if (m_addr !== 16'h0012) begin bad++; $display("FAIL pe2_hold_addr got=%h want=0012", m_addr); end
    if (m_data !== 16'hCCCC) begin bad++; $display("FAIL pe2_hold_data got=%h want=CCCC", m_data); end
  endtask

  // PE0 holds 10 items: 4 in slot 0, 4 in slot 4, 2 in slot 8.
  task automatic test_pe0_multi_slot();
    int          ec [] = '{4, 5, 6, 7, 28, 29, 30, 31, 52, 53};
    logic [15:0] ea [] = new[10];
    logic [15:0] ed [] = new[10];
    logic [1:0]  ek [] = new[10];
    clear_fifos();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      push_item(0, 16'h0100 + 16'(k), 16'h5000 + 16'(k));
      ea[k] = 16'h0100 + 16'(k);
      ed[k] = 16'h5000 + 16'(k);
      ek[k] = 2'd0;
    end
    run_to(58);
    check_events("pe0", 10, ec, ea, ed, ek);
  endtask

  // Reset during PE1's request phase drops its three in-flight items; the fourth
  // is forwarded from the next PE1 slot once scheduling restarts at PE0.
  task automatic test_reset_mid_slot();
    int          ec0 [] = '{4, 5};
    logic [15:0] ea0 [] = '{16'h0200, 16'h0201};
    logic [15:0] ed0 [] = '{16'h6000, 16'h6001};
    logic [1:0]  ek0 [] = '{2'd0, 2'd0};
    int          ec1 [] = '{10};
    logic [15:0] ea1 [] = '{16'h0303};
    logic [15:0] ed1 [] = '{16'h7003};
    logic [1:0]  ek1 [] = '{2'd1};
    clear_fifos();
    do_reset();
    push_item(0, 16'h0200, 16'h6000);
    push_item(0, 16'h0201, 16'h6001);
    for (int k = 0; k < 4; k++) push_item(1, 16'h0300 + 16'(k), 16'h7000 + 16'(k));
    run_to(9);
    check_events("pre_rst", 2, ec0, ea0, ed0, ek0);
    do_reset();
    total += 3;
    if (fifo_req_r !== 4'b0000) begin bad++; $display("FAIL midrst_req0 got=%b want=0000", fifo_req_r); end
    if (m_we !== 1'b0) begin bad++; $display("FAIL midrst_we0 got=%b want=0", m_we); end
    if (m_addr !== 16'h0000) begin bad++; $display("FAIL midrst_addr got=%h want=0000", m_addr); end
    step();
    total += 2;
    if (fifo_req_r !== 4'b0001) begin bad++; $display("FAIL midrst_req1 got=%b want=0001", fifo_req_r); end
    if (m_we !== 1'b0) begin bad++; $display("FAIL midrst_we1 got=%b want=0", m_we); end
    run_to(16);
    check_events("post_rst", 1, ec1, ea1, ed1, ek1);
  endtask

`ifdef MINI16_S2M_ARB_COUNT_EN
  // 4 items from PE1 (writes 10..13) and 3 from PE3 (writes 22..24), then wrap.
  task automatic test_count();
    clear_fifos();
    do_reset();
    for (int k = 0; k < 4; k++) push_item(1, 16'h0400 + 16'(k), 16'h8000 + 16'(k));
    for (int k = 0; k < 3; k++) push_item(3, 16'h0500 + 16'(k), 16'h9000 + 16'(k));
    run_to(24);
    push_item(0, 16'h0600, 16'hA000);
    step();
    total++;
    if (m_count !== 32'd7) begin bad++; $display("FAIL count_7 got=%h want=00000007", m_count); end
    force dut.m_count = 32'hFFFF_FFFF;
    step();
    release dut.m_count;
    total++;
    if (m_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL count_preload got=%h want=ffffffff", m_count); end
    run_to(28);
    total += 3;
    if (m_we !== 1'b1) begin bad++; $display("FAIL count_we got=%b want=1", m_we); end
    if (m_data !== 16'hA000) begin bad++; $display("FAIL count_data got=%h want=a000", m_data); end
    if (m_count !== 32'd0) begin bad++; $display("FAIL count_wrap got=%h want=00000000", m_count); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b1;
    fifo_valid  = {N_CORES{1'b0}};
    fifo_r_data = {(N_CORES*ITEM_W){1'b0}};
    test_reset();
    test_idle();
    test_pe2_burst();
    test_pe0_multi_slot();
    test_reset_mid_slot();
`ifdef MINI16_S2M_ARB_COUNT_EN
    test_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
